// File: rtl/voice_mixer_pwm.sv
// voice_mixer_pwm
//   Output stage for the organ oscillator bank. Each voice has its key button
//   synchronised and debounced into a gate. The gate drives a linear
//   attack/release envelope. Voices whose oscillator is currently high add
//   their envelope level into a registered mix sum. A first-order
//   sigma-delta modulator turns that sum into a one-bit audio stream.
//
// Ports
//   clk        system clock; all logic runs on the rising edge
//   rst        synchronous, active-high reset
//   osc_in     [NUM_VOICES]  oscillator square waves, already in the clk domain
//   btn_n      [NUM_VOICES]  raw key buttons, active-low, asynchronous
//   gate       [NUM_VOICES]  debounced key state, 1 = pressed
//   mix_level  [SUM_W]       registered sum of the gated envelope levels
//   pwmout                   sigma-delta audio bitstream
module voice_mixer_pwm #(
  parameter int NUM_VOICES      = 3,
  parameter int ENV_BITS        = 8,
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int ATTACK_DIV      = 1200,
  parameter int RELEASE_DIV     = 4800,
  localparam int SUM_W          = ENV_BITS + $clog2(NUM_VOICES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_VOICES-1:0] osc_in,
  input  logic [NUM_VOICES-1:0] btn_n,
  output logic [NUM_VOICES-1:0] gate,
  output logic [SUM_W-1:0]      mix_level,
  output logic                  pwmout
);

  localparam int ACC_W  = SUM_W + 1;
  localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PA_W   = $clog2(ATTACK_DIV + 1);
  localparam int PR_W   = $clog2(RELEASE_DIV + 1);
  localparam logic [ENV_BITS-1:0] ENV_MAX_C = '1;
  localparam logic [ACC_W-1:0]    FULL_C    = ACC_W'(NUM_VOICES * ((1 << ENV_BITS) - 1));

  // Two-flop synchroniser. Both stages reset to 1 so every key reads as
  // released when reset is removed.
  logic [NUM_VOICES-1:0] r_sync1;
  logic [NUM_VOICES-1:0] r_sync2;
  logic [NUM_VOICES-1:0] w_pressed;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= btn_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pressed = ~r_sync2;

  // Shared free-running prescalers. They count from reset release, so tick
  // phase does not depend on when a key is pressed.
  logic [PA_W-1:0] r_pa;
  logic [PR_W-1:0] r_pr;
  logic            w_tick_a;
  logic            w_tick_r;

  assign w_tick_a = (r_pa == PA_W'(ATTACK_DIV - 1));
  assign w_tick_r = (r_pr == PR_W'(RELEASE_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pa <= '0;
      r_pr <= '0;
    end else begin
      r_pa <= w_tick_a ? '0 : r_pa + PA_W'(1);
      r_pr <= w_tick_r ? '0 : r_pr + PR_W'(1);
    end
  end

  // Per-voice debounce and envelope.
  logic [ENV_BITS-1:0] w_env [NUM_VOICES];

  generate
    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
      logic              r_gate;
      logic [DCNT_W-1:0] r_dcnt;
      logic [ENV_BITS-1:0] r_env;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_gate <= 1'b0;
          r_dcnt <= '0;
          r_env  <= '0;
        end else begin
          // Any sample that agrees with the current gate restarts the count,
          // so the gate flips only after a full unbroken disagreeing run.
          if (w_pressed[gi] == r_gate) begin
            r_dcnt <= '0;
          end else if (r_dcnt == DCNT_W'(DEBOUNCE_CYCLES - 1)) begin
            r_gate <= w_pressed[gi];
            r_dcnt <= '0;
          end else begin
            r_dcnt <= r_dcnt + DCNT_W'(1);
          end

          // The envelope moves one step from its current level in whichever
          // direction the gate selects, so a gate reversal mid-ramp never
          // makes the level jump.
          if (w_tick_a && r_gate && (r_env != ENV_MAX_C)) begin
            r_env <= r_env + ENV_BITS'(1);
          end else if (w_tick_r && !r_gate && (r_env != '0)) begin
            r_env <= r_env - ENV_BITS'(1);
          end
        end
      end

      assign gate[gi]  = r_gate;
      assign w_env[gi] = r_env;
    end
  endgenerate

  // Mixer. SUM_W has room for NUM_VOICES * ENV_MAX, so the sum is exact.
  logic [SUM_W-1:0] w_sum;
  logic [SUM_W-1:0] r_mix;

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (osc_in[i]) begin
        w_sum = w_sum + SUM_W'(w_env[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mix <= '0;
    end else begin
      r_mix <= w_sum;
    end
  end

  assign mix_level = r_mix;

  // First-order sigma-delta. The accumulator stays below FULL, so t stays
  // below 2*FULL and fits in ACC_W bits.
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_t;
  logic             r_pwm;

  assign w_t = r_acc + ACC_W'(r_mix);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_pwm <= 1'b0;
    end else if (w_t >= FULL_C) begin
      r_acc <= w_t - FULL_C;
      r_pwm <= 1'b1;
    end else begin
      r_acc <= w_t;
      r_pwm <= 1'b0;
    end
  end

  assign pwmout = r_pwm;

endmodule

// File: tb/tb_voice_mixer_pwm.sv
// Testbench for voice_mixer_pwm. A behavioural model built from the
// key/envelope/mixer/sigma-delta rules is stepped on every clock edge, and
// the DUT outputs are compared with it on the falling edge. Directed checks
// cover the debounce latency, saturation, release and density points.
module tb_voice_mixer_pwm;
  localparam int NV   = 3;
  localparam int EB   = 8;
  localparam int DB   = 4;
  localparam int AD   = 2;
  localparam int RD   = 3;
  localparam int SW   = EB + $clog2(NV);
  localparam int EMAX = (1 << EB) - 1;
  localparam int FULL = NV * EMAX;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NV-1:0] osc_in = '0;
  logic [NV-1:0] btn_n = '1;
  logic [NV-1:0] gate;
  logic [SW-1:0] mix_level;
  logic          pwmout;

  int checks = 0;
  int errors = 0;

  voice_mixer_pwm #(
    .NUM_VOICES(NV), .ENV_BITS(EB), .DEBOUNCE_CYCLES(DB),
    .ATTACK_DIV(AD), .RELEASE_DIV(RD)
  ) dut (
    .clk(clk), .rst(rst), .osc_in(osc_in), .btn_n(btn_n),
    .gate(gate), .mix_level(mix_level), .pwmout(pwmout)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [NV-1:0] m_d1 = '1;
  logic [NV-1:0] m_d2 = '1;
  logic [NV-1:0] m_gate = '0;
  int            m_run [NV];
  int            m_env [NV];
  int            m_cyc = 0;
  int            m_mix = 0;
  int            m_acc = 0;
  logic          m_pwm = 1'b0;

  task automatic model_step(input logic r, input logic [NV-1:0] osc, input logic [NV-1:0] bn);
    int            new_env [NV];
    logic [NV-1:0] pressed;
    logic [NV-1:0] new_gate;
    int            new_mix;
    int            t;
    bit            ta;
    bit            tr;
    if (r) begin
      m_d1 = '1; m_d2 = '1; m_gate = '0;
      for (int i = 0; i < NV; i++) begin m_run[i] = 0; m_env[i] = 0; end
      m_cyc = 0; m_mix = 0; m_acc = 0; m_pwm = 1'b0;
    end else begin
      pressed = ~m_d2;
      ta = ((m_cyc % AD) == AD - 1);
      tr = ((m_cyc % RD) == RD - 1);
      new_mix = 0;
      for (int i = 0; i < NV; i++) if (osc[i]) new_mix += m_env[i];
      for (int i = 0; i < NV; i++) begin
        new_env[i] = m_env[i];
        if (ta && m_gate[i])       new_env[i] = (m_env[i] + 1 > EMAX) ? EMAX : m_env[i] + 1;
        else if (tr && !m_gate[i]) new_env[i] = (m_env[i] - 1 < 0) ? 0 : m_env[i] - 1;
      end
      new_gate = m_gate;
      for (int i = 0; i < NV; i++) begin
        if (pressed[i] != m_gate[i]) begin
          m_run[i]++;
          if (m_run[i] >= DB) begin new_gate[i] = pressed[i]; m_run[i] = 0; end
        end else begin
          m_run[i] = 0;
        end
      end
      t = m_acc + m_mix;
      if (t >= FULL) begin m_acc = t - FULL; m_pwm = 1'b1; end
      else begin m_acc = t; m_pwm = 1'b0; end
      for (int i = 0; i < NV; i++) m_env[i] = new_env[i];
      m_gate = new_gate;
      m_mix  = new_mix;
      m_d2   = m_d1;
      m_d1   = bn;
      m_cyc++;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(rst, osc_in, btn_n);
    @(negedge clk);
    checks++;
    assert (gate === m_gate) else begin
      errors++;
      $error("FAIL gate observed %b expected %b", gate, m_gate);
    end
    checks++;
    assert (mix_level === SW'(m_mix)) else begin
      errors++;
      $error("FAIL mix_level observed %0d expected %0d", mix_level, m_mix);
    end
    checks++;
    assert (pwmout === m_pwm) else begin
      errors++;
      $error("FAIL pwmout observed %b expected %b", pwmout, m_pwm);
    end
  endtask

  initial begin
    int lat;
    int n;
    int ones;
    int len;

    // 1: reset held with oscillators toggling
    rst = 1'b1; btn_n = '1;
    repeat (5) begin osc_in = NV'($urandom_range(0, 7)); tick(); end
    rst = 1'b0;
    repeat (4) begin osc_in = NV'($urandom_range(0, 7)); tick(); end
    chk("reset_gate", int'(gate), 0);
    chk("reset_mix", int'(mix_level), 0);
    chk("reset_pwm", int'(pwmout), 0);

    // 2: bounce on voice 0, then a clean press
    btn_n[0] = 1'b0;
    repeat (3) begin osc_in = NV'($urandom_range(0, 7)); tick(); end
    btn_n[0] = 1'b1;
    osc_in = NV'($urandom_range(0, 7)); tick();
    btn_n[0] = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      osc_in = NV'($urandom_range(0, 7));
      tick();
      if (gate[0]) begin lat = k; break; end
    end
    chk("bounce_latency", lat, DB + 2);

    // random short bounces on voice 1 must never reach the gate
    repeat (6) begin
      len = $urandom_range(1, DB - 1);
      btn_n[1] = 1'b0;
      repeat (len) tick();
      btn_n[1] = 1'b1;
      repeat ($urandom_range(1, 2)) tick();
    end
    repeat (DB + 2) tick();
    chk("bounce_ignored", int'(gate[1]), 0);

    // 3: attack to saturation
    osc_in = 3'b001;
    n = 0;
    while (mix_level != SW'(EMAX) && n < 1200) begin tick(); n++; end
    chk("attack_reaches_max", int'(mix_level), EMAX);
    repeat (20) tick();
    chk("attack_saturates", int'(mix_level), EMAX);

    // 4: release, re-press, release again mid-attack at level 100
    btn_n[0] = 1'b1;
    n = 0;
    while (mix_level != '0 && n < 1500) begin tick(); n++; end
    chk("release_to_zero", int'(mix_level), 0);
    btn_n[0] = 1'b0;
    n = 0;
    while (mix_level != SW'(100) && n < 1500) begin tick(); n++; end
    chk("mid_attack_level", int'(mix_level), 100);
    btn_n[0] = 1'b1;
    n = 0;
    while (mix_level != '0 && n < 1500) begin tick(); n++; end
    chk("mid_release_zero", int'(mix_level), 0);
    repeat (20) tick();
    chk("release_stays_zero", int'(mix_level), 0);

    // 5: pulse density with voice 0 at full scale
    btn_n[0] = 1'b0;
    n = 0;
    while (mix_level != SW'(EMAX) && n < 1500) begin tick(); n++; end
    chk("density_setup", int'(mix_level), EMAX);
    osc_in = 3'b111;
    repeat (5) tick();
    for (int w = 0; w < 2; w++) begin
      ones = 0;
      repeat (FULL) begin tick(); ones += int'(pwmout); end
      chk("density_window", ones, EMAX);
    end

    // 6: reset with all voices at full scale
    btn_n = '0;
    repeat (600) begin osc_in = NV'($urandom_range(0, 7)); tick(); end
    osc_in = 3'b111;
    tick();
    chk("all_full_mix", int'(mix_level), FULL);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midreset_gate", int'(gate), 0);
    chk("midreset_mix", int'(mix_level), 0);
    chk("midreset_pwm", int'(pwmout), 0);
    repeat (3) tick();
    chk("restart_mix_zero", int'(mix_level), 0);
    repeat (40) begin osc_in = NV'($urandom_range(0, 7)); tick(); end
    chk("restart_gate", int'(gate), 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
